// File: rtl/flag_branch_unit.sv
// -----------------------------------------------------------------------------
// flag_branch_unit
//   Architectural N/V/Z flag register written by the EX-stage ALU, plus the
//   resolver for the conditional branch sitting in ID.
//
//   With BYPASS=0 the branch only ever looks at registered flags. While any
//   flag writer is still in EX (stalled or not), ID is held off with br_wait.
//   With BYPASS=1 the branch looks at the flag values that will be registered
//   at the coming edge, so it never has to wait.
//
//   Two saturating performance counters record resolved and taken branches.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   ex_valid/ex_stall/ex_flush  EX-stage qualifiers
//   alu_N/V/Z, alu_N/V/Z_en     ALU flag results and their per-flag enables
//   br_valid, br_cond[2:0]      ID holds a conditional branch and its condition
//   br_wait                     hold ID: the branch cannot resolve this cycle
//   br_taken                    branch resolved taken this cycle
//   flag_N/V/Z                  architectural flags
//   cnt_eval, cnt_taken         saturating counts of resolved / taken branches
// -----------------------------------------------------------------------------
module flag_branch_unit #(
  parameter bit BYPASS = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_flush,
  input  logic             alu_N,
  input  logic             alu_V,
  input  logic             alu_Z,
  input  logic             alu_N_en,
  input  logic             alu_V_en,
  input  logic             alu_Z_en,
  input  logic             br_valid,
  input  logic [2:0]       br_cond,
  output logic             br_wait,
  output logic             br_taken,
  output logic             flag_N,
  output logic             flag_V,
  output logic             flag_Z,
  output logic [CNT_W-1:0] cnt_eval,
  output logic [CNT_W-1:0] cnt_taken
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    C_NE   = 3'd0,
    C_EQ   = 3'd1,
    C_GT   = 3'd2,
    C_LT   = 3'd3,
    C_GE   = 3'd4,
    C_LE   = 3'd5,
    C_OVFL = 3'd6,
    C_AL   = 3'd7
  } cond_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_next;

  logic commit;
  logic writer;
  logic n_next, v_next, z_next;
  logic eval_n, eval_v, eval_z;
  logic cond_true;
  logic wait_raw;
  logic resolve;

  // A stalled instruction does not commit, but it still counts as a writer:
  // its flags are on the way, so a non-bypassed branch must keep waiting.
  assign commit = ex_valid & ~ex_stall & ~ex_flush;
  assign writer = ex_valid & ~ex_flush & (alu_N_en | alu_V_en | alu_Z_en);

  // Flag values that will be registered at the coming edge.
  assign n_next = (commit & alu_N_en) ? alu_N : flag_N;
  assign v_next = (commit & alu_V_en) ? alu_V : flag_V;
  assign z_next = (commit & alu_Z_en) ? alu_Z : flag_Z;

  assign eval_n = BYPASS ? n_next : flag_N;
  assign eval_v = BYPASS ? v_next : flag_V;
  assign eval_z = BYPASS ? z_next : flag_Z;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case can leave it unassigned and infer a latch.
    cond_true = 1'b0;
    unique case (cond_t'(br_cond))
      C_NE:   cond_true = ~eval_z;
      C_EQ:   cond_true = eval_z;
      C_GT:   cond_true = ~eval_z & ~eval_n;
      C_LT:   cond_true = eval_n;
      C_GE:   cond_true = eval_z | ~eval_n;
      C_LE:   cond_true = eval_n | eval_z;
      C_OVFL: cond_true = eval_v;
      C_AL:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // Branch resolution FSM. Only the stalling variant ever leaves IDLE.
  always_comb begin
    state_next = state;
    wait_raw   = 1'b0;
    resolve    = 1'b0;
    if (BYPASS) begin
      state_next = IDLE;
      resolve    = br_valid;
    end else begin
      unique case (state)
        IDLE: begin
          if (br_valid && writer) begin
            wait_raw   = 1'b1;
            state_next = HOLD;
          end else begin
            resolve = br_valid;
          end
        end
        HOLD: begin
          if (!br_valid) begin
            // ID was flushed underneath the waiting branch: drop it silently.
            state_next = IDLE;
          end else if (writer) begin
            wait_raw = 1'b1;
          end else begin
            resolve    = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Both handshake outputs are forced low while reset is held, independent
  // of whatever the pipeline inputs happen to be doing.
  assign br_wait  = rst_n & wait_raw;
  assign br_taken = rst_n & resolve & cond_true;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: flags and counters are architecturally visible, so they all sit
  // on the asynchronous reset rather than relying on a software clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_N <= 1'b0;
      flag_V <= 1'b0;
      flag_Z <= 1'b0;
    end else begin
      flag_N <= n_next;
      flag_V <= v_next;
      flag_Z <= z_next;
    end
  end

  // Saturating performance counters: they stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_eval  <= '0;
      cnt_taken <= '0;
    end else if (resolve) begin
      if (cnt_eval != CNT_MAX) begin
        cnt_eval <= cnt_eval + CNT_W'(1);
      end
      if (cond_true && (cnt_taken != CNT_MAX)) begin
        cnt_taken <= cnt_taken + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_flag_branch_unit
//   Three instances share one stimulus stream:
//     u0: BYPASS=0, CNT_W=16    u1: BYPASS=1, CNT_W=16    u2: BYPASS=0, CNT_W=4
//   A behavioural model keeps flags and counters as plain bits/ints and
//   derives expected outputs from the condition table and commit rules.
// -----------------------------------------------------------------------------
module tb_flag_branch_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic ex_valid, ex_stall, ex_flush;
  logic alu_N, alu_V, alu_Z;
  logic alu_N_en, alu_V_en, alu_Z_en;
  logic br_valid;
  logic [2:0] br_cond;

  logic [2:0]  br_wait_s, br_taken_s, fn_s, fv_s, fz_s;
  logic [15:0] cnt_eval0, cnt_taken0, cnt_eval1, cnt_taken1;
  logic [3:0]  cnt_eval2, cnt_taken2;

  int errors = 0;
  int checks = 0;

  // Model state
  bit m_n[3], m_v[3], m_z[3];
  int m_eval[3], m_taken[3];
  bit byp[3]  = '{1'b0, 1'b1, 1'b0};
  int cmax[3] = '{65535, 65535, 15};

  always #5 clk = ~clk;

  flag_branch_unit #(.BYPASS(1'b0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_flush(ex_flush), .alu_N(alu_N), .alu_V(alu_V), .alu_Z(alu_Z),
    .alu_N_en(alu_N_en), .alu_V_en(alu_V_en), .alu_Z_en(alu_Z_en),
    .br_valid(br_valid), .br_cond(br_cond), .br_wait(br_wait_s[0]),
    .br_taken(br_taken_s[0]), .flag_N(fn_s[0]), .flag_V(fv_s[0]),
    .flag_Z(fz_s[0]), .cnt_eval(cnt_eval0), .cnt_taken(cnt_taken0));

  flag_branch_unit #(.BYPASS(1'b1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_flush(ex_flush), .alu_N(alu_N), .alu_V(alu_V), .alu_Z(alu_Z),
    .alu_N_en(alu_N_en), .alu_V_en(alu_V_en), .alu_Z_en(alu_Z_en),
    .br_valid(br_valid), .br_cond(br_cond), .br_wait(br_wait_s[1]),
    .br_taken(br_taken_s[1]), .flag_N(fn_s[1]), .flag_V(fv_s[1]),
    .flag_Z(fz_s[1]), .cnt_eval(cnt_eval1), .cnt_taken(cnt_taken1));

  flag_branch_unit #(.BYPASS(1'b0), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_flush(ex_flush), .alu_N(alu_N), .alu_V(alu_V), .alu_Z(alu_Z),
    .alu_N_en(alu_N_en), .alu_V_en(alu_V_en), .alu_Z_en(alu_Z_en),
    .br_valid(br_valid), .br_cond(br_cond), .br_wait(br_wait_s[2]),
    .br_taken(br_taken_s[2]), .flag_N(fn_s[2]), .flag_V(fv_s[2]),
    .flag_Z(fz_s[2]), .cnt_eval(cnt_eval2), .cnt_taken(cnt_taken2));

  // ---------------------------------------------------------------- accessors
  function automatic logic [2:0] get_flags(input int i);
    return {fn_s[i], fv_s[i], fz_s[i]};
  endfunction

  function automatic logic [15:0] get_eval(input int i);
    case (i)
      0:       return cnt_eval0;
      1:       return cnt_eval1;
      default: return {12'd0, cnt_eval2};
    endcase
  endfunction

  function automatic logic [15:0] get_tcnt(input int i);
    case (i)
      0:       return cnt_taken0;
      1:       return cnt_taken1;
      default: return {12'd0, cnt_taken2};
    endcase
  endfunction

  // ------------------------------------------------------------------- model
  function automatic bit cond_ok(input logic [2:0] c, input bit n, v, z);
    case (c)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || !n;
      3'd5:    return n || z;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit m_commit();
    return ex_valid && !ex_stall && !ex_flush;
  endfunction

  function automatic bit m_writer();
    return ex_valid && !ex_flush && (alu_N_en || alu_V_en || alu_Z_en);
  endfunction

  task automatic m_expect(input int i, output bit w, output bit t);
    bit fn, fv, fz;
    fn = m_n[i]; fv = m_v[i]; fz = m_z[i];
    if (byp[i] && m_commit()) begin
      if (alu_N_en) fn = alu_N;
      if (alu_V_en) fv = alu_V;
      if (alu_Z_en) fz = alu_Z;
    end
    w = !byp[i] && br_valid && m_writer();
    t = br_valid && !w && cond_ok(br_cond, fn, fv, fz);
  endtask

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_n[i] = 0; m_v[i] = 0; m_z[i] = 0; m_eval[i] = 0; m_taken[i] = 0;
    end
  endtask

  task automatic m_clock();
    bit w, t;
    for (int i = 0; i < 3; i++) begin
      m_expect(i, w, t);
      if (br_valid && !w) begin
        if (m_eval[i] < cmax[i]) m_eval[i]++;
        if (t && m_taken[i] < cmax[i]) m_taken[i]++;
      end
      if (m_commit()) begin
        if (alu_N_en) m_n[i] = alu_N;
        if (alu_V_en) m_v[i] = alu_V;
        if (alu_Z_en) m_z[i] = alu_Z;
      end
    end
  endtask

  // Crosses the next rising edge; the model advances on the pre-edge inputs.
  task automatic advance();
    @(posedge clk);
    if (!rst_n) m_reset();
    else        m_clock();
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_stall = 0; ex_flush = 0;
    alu_N = 0; alu_V = 0; alu_Z = 0;
    alu_N_en = 0; alu_V_en = 0; alu_Z_en = 0;
    br_valid = 0; br_cond = 3'd0;
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    m_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_flags(i) !== 3'b000 || get_eval(i) !== 16'd0 || get_tcnt(i) !== 16'd0
          || br_wait_s[i] !== 1'b0 || br_taken_s[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: flags=%b eval=%0d taken_cnt=%0d wait=%b taken=%b, want all 0",
                 i, get_flags(i), get_eval(i), get_tcnt(i), br_wait_s[i], br_taken_s[i]);
      end
    end
    advance();
    rst_n = 1;
  endtask

  task automatic test_partial_enable();
    idle_inputs();
    ex_valid = 1; alu_N = 1; alu_Z = 1; alu_N_en = 1; alu_Z_en = 1;
    advance();
    alu_N = 0; alu_Z = 0; alu_N_en = 0; alu_Z_en = 1;
    advance();
    idle_inputs();
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_flags(i) !== 3'b100) begin
        errors++;
        $display("FAIL partial_enable[%0d]: NVZ=%b, want 100", i, get_flags(i));
      end
    end
  endtask

  task automatic test_stall();
    idle_inputs();
    ex_valid = 1; alu_Z = 1; alu_Z_en = 1; alu_N = 0; alu_N_en = 1;
    br_valid = 1; br_cond = 3'd1;
    @(negedge clk);
    checks++;
    if (br_wait_s !== 3'b101 || br_taken_s !== 3'b010) begin
      errors++;
      $display("FAIL stall_commit_cycle: wait=%b taken=%b, want wait=101 taken=010",
               br_wait_s, br_taken_s);
    end
    advance();
    checks++;
    if (cnt_eval1 !== 16'd1 || cnt_taken1 !== 16'd1 || cnt_eval0 !== 16'd0) begin
      errors++;
      $display("FAIL bypass_count: u1 eval=%0d taken=%0d u0 eval=%0d, want 1 1 0",
               cnt_eval1, cnt_taken1, cnt_eval0);
    end
    ex_valid = 0; alu_Z_en = 0; alu_N_en = 0;
    @(negedge clk);
    checks++;
    if (br_wait_s[0] !== 1'b0 || br_taken_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL stall_resolve: wait=%b taken=%b, want 0 1", br_wait_s[0], br_taken_s[0]);
    end
    advance();
    br_valid = 0;
    checks++;
    if (cnt_eval0 !== 16'd1 || cnt_taken0 !== 16'd1) begin
      errors++;
      $display("FAIL stall_counts: eval=%0d taken=%0d, want 1 1", cnt_eval0, cnt_taken0);
    end
  endtask

  task automatic test_cond_table();
    bit w, t;
    for (int f = 0; f < 8; f++) begin
      idle_inputs();
      ex_valid = 1; alu_N_en = 1; alu_V_en = 1; alu_Z_en = 1;
      {alu_N, alu_V, alu_Z} = 3'(f);
      advance();
      idle_inputs();
      br_valid = 1;
      for (int c = 0; c < 8; c++) begin
        br_cond = 3'(c);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          m_expect(i, w, t);
          checks++;
          if (br_taken_s[i] !== t || br_wait_s[i] !== 1'b0) begin
            errors++;
            $display("FAIL cond_table[%0d] NVZ=%b cond=%0d: taken=%b wait=%b, want %b 0",
                     i, 3'(f), c, br_taken_s[i], br_wait_s[i], t);
          end
        end
        advance();
      end
    end
    idle_inputs();
  endtask

  task automatic test_flush_stall();
    idle_inputs();
    ex_valid = 1; alu_Z_en = 1; alu_Z = 1; alu_N_en = 1; alu_V_en = 1;
    advance();                                     // flags NVZ = 001
    alu_N_en = 0; alu_V_en = 0;
    ex_flush = 1; alu_Z = 0; br_valid = 1; br_cond = 3'd1;
    @(negedge clk);
    checks++;
    if (br_wait_s !== 3'b000) begin
      errors++;
      $display("FAIL flush_wait: wait=%b, want 000", br_wait_s);
    end
    advance();
    checks++;
    if (fz_s !== 3'b111) begin
      errors++;
      $display("FAIL flush_hold: Z=%b, want 111", fz_s);
    end
    ex_flush = 0; ex_stall = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (br_wait_s !== 3'b101 || br_taken_s !== 3'b010 || fz_s !== 3'b111) begin
        errors++;
        $display("FAIL ex_stall cycle %0d: wait=%b taken=%b Z=%b, want 101 010 111",
                 k, br_wait_s, br_taken_s, fz_s);
      end
      advance();
    end
    ex_stall = 0;                                  // commit Z=0, u0 still waits
    advance();
    ex_valid = 0; alu_Z_en = 0;
    @(negedge clk);
    checks++;
    if (br_wait_s[0] !== 1'b0 || br_taken_s[0] !== 1'b0 || fz_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: wait=%b taken=%b Z=%b, want 0 0 0",
               br_wait_s[0], br_taken_s[0], fz_s[0]);
    end
    advance();
    idle_inputs();
  endtask

  task automatic test_reset_mid_hold();
    idle_inputs();
    ex_valid = 1; ex_stall = 1; alu_V = 1; alu_V_en = 1;
    br_valid = 1; br_cond = 3'd6;
    advance();                                     // u0/u2 now in HOLD
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_flags(i) !== 3'b000 || get_eval(i) !== 16'd0 || get_tcnt(i) !== 16'd0
          || br_wait_s[i] !== 1'b0 || br_taken_s[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_hold[%0d]: flags=%b eval=%0d tcnt=%0d wait=%b taken=%b, want 0",
                 i, get_flags(i), get_eval(i), get_tcnt(i), br_wait_s[i], br_taken_s[i]);
      end
    end
    advance();
    rst_n = 1;
    idle_inputs();
  endtask

  task automatic test_saturation();
    idle_inputs();
    br_valid = 1; br_cond = 3'd7;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (cnt_eval2 !== 4'((k < 15) ? k : 15) || cnt_taken2 !== 4'((k < 15) ? k : 15)) begin
        errors++;
        $display("FAIL saturation step %0d: eval=%0d taken=%0d, want %0d",
                 k, cnt_eval2, cnt_taken2, (k < 15) ? k : 15);
      end
      advance();
    end
    idle_inputs();
    checks++;
    if (cnt_eval2 !== 4'hF || cnt_taken2 !== 4'hF || cnt_eval0 !== 16'd20) begin
      errors++;
      $display("FAIL saturation_final: u2 eval=%0h taken=%0h u0 eval=%0d, want F F 20",
               cnt_eval2, cnt_taken2, cnt_eval0);
    end
  endtask

  task automatic test_random();
    bit w, t;
    for (int k = 0; k < 400; k++) begin
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_stall = ($urandom_range(0, 4) == 0);
      ex_flush = ($urandom_range(0, 6) == 0);
      {alu_N, alu_V, alu_Z} = 3'($urandom);
      {alu_N_en, alu_V_en, alu_Z_en} = 3'($urandom);
      br_valid = ($urandom_range(0, 2) != 0);
      br_cond  = 3'($urandom);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        m_expect(i, w, t);
        checks++;
        if (br_wait_s[i] !== w || br_taken_s[i] !== t
            || get_flags(i) !== {m_n[i], m_v[i], m_z[i]}
            || get_eval(i) !== 16'(m_eval[i]) || get_tcnt(i) !== 16'(m_taken[i])) begin
          errors++;
          $display("FAIL random[%0d] step %0d: wait=%b taken=%b NVZ=%b eval=%0d tcnt=%0d, want %b %b %b %0d %0d",
                   i, k, br_wait_s[i], br_taken_s[i], get_flags(i), get_eval(i), get_tcnt(i),
                   w, t, {m_n[i], m_v[i], m_z[i]}, m_eval[i], m_taken[i]);
        end
      end
      advance();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_partial_enable();
    test_stall();
    test_cond_table();
    test_flush_stall();
    test_reset_mid_hold();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
